// File: rtl/cache_stream_reader.sv
// Sweeps a contiguous cache address range on the read port and delivers the
// returned words as a valid/ready stream through a small credit-managed FIFO.
module cache_stream_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned LEN_WIDTH  = 20,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = CW + 1;
    localparam int unsigned EW = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  ret_q, ret_d;
    logic [ADDR_WIDTH-1:0] addrb_q, addrb_d;
    logic                  s1_q, s1_d;
    logic                  s2_q, s2_d;
    logic                  busy_q, done_q, valid_q;
    logic [EW-1:0]         fifo_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  push_c, pop_c, push_last_c;
    logic [EW-1:0]         head_c;
    logic [OW-1:0]         occ_c, lim_c;

    assign push_c      = s2_q;
    assign pop_c       = valid_q & m_ready;
    assign head_c      = fifo_q[rd_ptr_q];
    assign push_last_c = (ret_q == len_q - LEN_WIDTH'(1));

    // Credit check: buffered plus in-flight words must leave room for every return.
    assign occ_c = OW'(count_q) + OW'(s1_q) + OW'(s2_q);
    assign lim_c = OW'(FIFO_DEPTH) + OW'(pop_c);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q;
        ret_d    = ret_q;
        addrb_d  = addrb_q;
        s1_d     = 1'b0;
        s2_d     = s1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_c) - CW'(pop_c);

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            ret_d    = ret_q + LEN_WIDTH'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    len_d    = length;
                    issued_d = '0;
                    ret_d    = '0;
                    state_d  = (length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if ((issued_q < len_q) && (occ_c < lim_c)) begin
                    addrb_d  = base_q + ADDR_WIDTH'(issued_q);
                    issued_d = issued_q + LEN_WIDTH'(1);
                    s1_d     = 1'b1;
                end
                if (pop_c && head_c[DATA_WIDTH]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            ret_q    <= '0;
            addrb_q  <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            ret_q    <= ret_d;
            addrb_q  <= addrb_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
            valid_q  <= (count_d != '0);
        end
    end

    // Output buffer storage; the last flag travels with each word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push_c) begin
            fifo_q[wr_ptr_q] <= {push_last_c, doutb};
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign addrb   = addrb_q;
    assign m_valid = valid_q;
    assign m_data  = head_c[DATA_WIDTH-1:0];
    assign m_last  = head_c[DATA_WIDTH] & valid_q;

endmodule

// File: tb/tb_cache_stream_reader.sv
// Directed bench for cache_stream_reader with a 1-cycle-latency cache model.
module tb_cache_stream_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 19;
    localparam int unsigned LW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy, done;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc;
    int done_cnt;
    logic [DW-1:0] cap_data [$];
    logic          cap_last [$];
    int            cap_cyc  [$];

    cache_stream_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .addrb(addrb),
        .doutb(doutb), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {13'h1A5, a};
    endfunction

    // Cache model: data for the address sampled at an edge appears after it.
    always @(posedge clk) doutb <= memf(addrb);

    // One cycle: drive at the falling edge, then record a beat that will handshake.
    task automatic tick(input logic rdy);
        @(negedge clk);
        start   = 1'b0;
        m_ready = rdy;
        cyc++;
        if (m_valid && m_ready) begin
            cap_data.push_back(m_data);
            cap_last.push_back(m_last);
            cap_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
    endtask

    task automatic launch(input logic [AW-1:0] b, input logic [LW-1:0] l);
        start = 1'b1; base_addr = b; length = l;
        cyc = -1; done_cnt = 0;
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
    endtask

    task automatic run_until_done(input int budget);
        for (int n = 0; n < budget && done_cnt == 0; n++) tick(1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
        cyc = 0; done_cnt = 0;
        tick(1'b0); tick(1'b0);
        vec_cnt++; if (busy !== 1'b0)    begin err_cnt++; $display("FAIL reset_busy got %0b want 0", busy); end
        vec_cnt++; if (done !== 1'b0)    begin err_cnt++; $display("FAIL reset_done got %0b want 0", done); end
        vec_cnt++; if (addrb !== '0)     begin err_cnt++; $display("FAIL reset_addrb got %h want 0", addrb); end
        vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %0b want 0", m_valid); end
        vec_cnt++; if (m_last !== 1'b0)  begin err_cnt++; $display("FAIL reset_last got %0b want 0", m_last); end
        vec_cnt++; if (m_data !== '0)    begin err_cnt++; $display("FAIL reset_data got %h want 0", m_data); end
        rst_n = 1'b1;
        tick(1'b0);
    endtask

    task automatic test_basic;
        launch(19'h10, 20'd4);
        for (int c = 0; c < 10; c++) begin
            tick(1'b1);
            if (c >= 1 && c <= 4) begin
                vec_cnt++;
                if (addrb !== AW'(19'h10 + c - 1)) begin err_cnt++; $display("FAIL t1_addrb c=%0d got %h want %h", c, addrb, AW'(19'h10 + c - 1)); end
            end
            if (c == 7) begin
                vec_cnt++; if (done !== 1'b1 || busy !== 1'b1) begin err_cnt++; $display("FAIL t1_done c=7 got done=%0b busy=%0b want 1 1", done, busy); end
            end
            if (c == 8) begin
                vec_cnt++; if (done !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL t1_idle c=8 got done=%0b busy=%0b want 0 0", done, busy); end
            end
        end
        vec_cnt++; if (cap_data.size() != 4) begin err_cnt++; $display("FAIL t1_count got %0d want 4", cap_data.size()); end
        for (int i = 0; i < 4 && i < cap_data.size(); i++) begin
            vec_cnt++;
            if (cap_data[i] !== memf(AW'(19'h10 + i)) || cap_cyc[i] != 3 + i || cap_last[i] !== (i == 3))
                begin err_cnt++; $display("FAIL t1_beat%0d got %h cyc%0d last%0b want %h cyc%0d last%0b", i, cap_data[i], cap_cyc[i], cap_last[i], memf(AW'(19'h10 + i)), 3 + i, i == 3); end
        end
        vec_cnt++; if (done_cnt != 1) begin err_cnt++; $display("FAIL t1_done_pulses got %0d want 1", done_cnt); end
    endtask

    task automatic test_backpressure;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        launch(19'h40, 20'd8);
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (int n = 0; n < 80 && done_cnt == 0; n++) begin
            tick(n % 2 == 0);
            if (prev_stall && m_valid) begin
                vec_cnt++;
                if (m_data !== prev_data || m_last !== prev_last) begin err_cnt++; $display("FAIL t2_hold cyc=%0d got %h/%0b want %h/%0b", cyc, m_data, m_last, prev_data, prev_last); end
            end
            prev_stall = m_valid && !m_ready; prev_data = m_data; prev_last = m_last;
        end
        vec_cnt++; if (done_cnt != 1) begin err_cnt++; $display("FAIL t2_done got %0d pulses want 1 (timeout?)", done_cnt); end
        vec_cnt++; if (cap_data.size() != 8) begin err_cnt++; $display("FAIL t2_count got %0d want 8", cap_data.size()); end
        for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
            vec_cnt++;
            if (cap_data[i] !== memf(AW'(19'h40 + i)) || cap_last[i] !== (i == 7))
                begin err_cnt++; $display("FAIL t2_beat%0d got %h last%0b want %h last%0b", i, cap_data[i], cap_last[i], memf(AW'(19'h40 + i)), i == 7); end
        end
        tick(1'b1);
    endtask

    task automatic test_wrap;
        logic [AW-1:0] exp_a [4];
        exp_a[0] = 19'h7FFFE; exp_a[1] = 19'h7FFFF; exp_a[2] = 19'h00000; exp_a[3] = 19'h00001;
        launch(19'h7FFFE, 20'd4);
        for (int c = 0; c < 5; c++) begin
            tick(1'b1);
            if (c >= 1) begin
                vec_cnt++;
                if (addrb !== exp_a[c-1]) begin err_cnt++; $display("FAIL t3_addrb c=%0d got %h want %h", c, addrb, exp_a[c-1]); end
            end
        end
        run_until_done(40);
        vec_cnt++; if (cap_data.size() != 4) begin err_cnt++; $display("FAIL t3_count got %0d want 4", cap_data.size()); end
        for (int i = 0; i < 4 && i < cap_data.size(); i++) begin
            vec_cnt++;
            if (cap_data[i] !== memf(exp_a[i])) begin err_cnt++; $display("FAIL t3_beat%0d got %h want %h", i, cap_data[i], memf(exp_a[i])); end
        end
        tick(1'b1);
    endtask

    task automatic test_zero_len;
        int valid_seen;
        valid_seen = 0;
        launch(19'h123, 20'd0);
        tick(1'b1);
        vec_cnt++; if (done !== 1'b1 || busy !== 1'b1) begin err_cnt++; $display("FAIL t4_done got done=%0b busy=%0b want 1 1", done, busy); end
        if (m_valid) valid_seen++;
        tick(1'b1);
        vec_cnt++; if (done !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL t4_idle got done=%0b busy=%0b want 0 0", done, busy); end
        for (int n = 0; n < 5; n++) begin
            if (m_valid) valid_seen++;
            tick(1'b1);
        end
        vec_cnt++; if (valid_seen != 0 || done_cnt != 1) begin err_cnt++; $display("FAIL t4_quiet got valid=%0d done_pulses=%0d want 0 1", valid_seen, done_cnt); end
    endtask

    task automatic test_restart_ignored;
        launch(19'h100, 20'd6);
        tick(1'b1); tick(1'b1); tick(1'b1);
        start = 1'b1; base_addr = 19'h200; length = 20'd3;
        run_until_done(60);
        vec_cnt++; if (cap_data.size() != 6 || done_cnt != 1) begin err_cnt++; $display("FAIL t5_first got %0d beats %0d dones want 6 1", cap_data.size(), done_cnt); end
        for (int i = 0; i < 6 && i < cap_data.size(); i++) begin
            vec_cnt++;
            if (cap_data[i] !== memf(AW'(19'h100 + i)) || cap_last[i] !== (i == 5))
                begin err_cnt++; $display("FAIL t5_beat%0d got %h last%0b want %h last%0b", i, cap_data[i], cap_last[i], memf(AW'(19'h100 + i)), i == 5); end
        end
        tick(1'b1);
        launch(19'h200, 20'd3);
        run_until_done(60);
        vec_cnt++; if (cap_data.size() != 3 || done_cnt != 1) begin err_cnt++; $display("FAIL t5_second got %0d beats %0d dones want 3 1", cap_data.size(), done_cnt); end
        for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
            vec_cnt++;
            if (cap_data[i] !== memf(AW'(19'h200 + i)) || cap_last[i] !== (i == 2))
                begin err_cnt++; $display("FAIL t5b_beat%0d got %h last%0b want %h last%0b", i, cap_data[i], cap_last[i], memf(AW'(19'h200 + i)), i == 2); end
        end
        tick(1'b1);
    endtask

    task automatic test_mid_reset;
        int stray;
        launch(19'h300, 20'd16);
        for (int n = 0; n < 8; n++) tick(1'b0);
        vec_cnt++; if (m_valid !== 1'b1 || busy !== 1'b1) begin err_cnt++; $display("FAIL t6_stalled got valid=%0b busy=%0b want 1 1", m_valid, busy); end
        rst_n = 1'b0;
        tick(1'b0);
        rst_n = 1'b1;
        vec_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || addrb !== '0 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0)
            begin err_cnt++; $display("FAIL t6_reset got busy%0b done%0b addrb%h valid%0b last%0b data%h want all 0", busy, done, addrb, m_valid, m_last, m_data); end
        stray = 0;
        for (int n = 0; n < 6; n++) begin
            tick(1'b1);
            if (m_valid || done) stray++;
        end
        vec_cnt++; if (stray != 0) begin err_cnt++; $display("FAIL t6_quiet got %0d stray cycles want 0", stray); end
        launch(19'h55, 20'd5);
        run_until_done(60);
        vec_cnt++; if (cap_data.size() != 5 || done_cnt != 1) begin err_cnt++; $display("FAIL t6_fresh got %0d beats %0d dones want 5 1", cap_data.size(), done_cnt); end
        for (int i = 0; i < 5 && i < cap_data.size(); i++) begin
            vec_cnt++;
            if (cap_data[i] !== memf(AW'(19'h55 + i)) || cap_last[i] !== (i == 4))
                begin err_cnt++; $display("FAIL t6_beat%0d got %h last%0b want %h last%0b", i, cap_data[i], cap_last[i], memf(AW'(19'h55 + i)), i == 4); end
        end
        tick(1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_restart_ignored();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
